// File: rtl/alu_seq_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer.
package alu_seq_pkg;

  // Operation requested by the control unit
  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_ADC   = 2'b01,
    OP_SUB   = 2'b10,
    OP_LOGIC = 2'b11
  } op_t;

  // 4-bit ALU op select for A + B + c_in
  localparam logic [1:0] ALU_OP_ADD = 2'b10;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_nibble_seq.sv
// Drives an external 4-bit ALU one nibble per cycle, LSB first, chaining the
// carry, to execute a WIDTH-bit operation; result and flags are registered
// on the final nibble.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for start; alu_* held at 0
//  S_RUN  | one nibble per cycle through the ALU, index 0..NIBBLES-1
//  S_DONE | one-cycle done pulse, still busy; start not accepted here
module alu_nibble_seq
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       lop,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_s,
  output logic             flag_v,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic             alu_c_in,
  output logic [1:0]       alu_op,
  output logic             alu_l,
  input  logic [3:0]       alu_r,
  input  logic             alu_c_out
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q, acc, res_fin;
  op_t                op_q;
  logic [1:0]         lop_q;
  logic               cr;
  logic [IDX_W-1:0]   idx;
  logic               accept, arith, last;

  assign accept = (state == S_IDLE) && start;
  assign arith  = (op_q != OP_LOGIC);
  assign last   = (idx == IDX_W'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake and ALU drive; ALU inputs are 0 outside RUN
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_a     = 4'h0;
    alu_b     = 4'h0;
    alu_c_in  = 1'b0;
    alu_op    = 2'b00;
    alu_l     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        alu_a = a_q[{idx, 2'b00} +: 4];
        alu_b = b_q[{idx, 2'b00} +: 4];
        if (arith) begin
          alu_c_in = cr;
          alu_op   = ALU_OP_ADD;
        end else begin
          alu_l  = 1'b1;
          alu_op = lop_q;
        end
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator with the current ALU nibble merged in; on the last nibble
  // this is the full result, so flags can be registered in the same edge
  always_comb begin
    res_fin = acc;
    res_fin[{idx, 2'b00} +: 4] = alu_r;
  end

  // Operand latch, carry chain, nibble index and the visible result/flags.
  // The visible result only changes on the final nibble so it stays stable
  // while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      op_q   <= OP_ADD;
      lop_q  <= 2'b00;
      cr     <= 1'b0;
      idx    <= '0;
      result <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_s <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= (op_t'(op) == OP_SUB) ? ~b : b;
      op_q  <= op_t'(op);
      lop_q <= lop;
      acc   <= '0;
      idx   <= '0;
      case (op_t'(op))
        OP_ADC:  cr <= cin;
        OP_SUB:  cr <= 1'b1;
        default: cr <= 1'b0;
      endcase
    end else if (state == S_RUN) begin
      acc <= res_fin;
      cr  <= arith ? alu_c_out : 1'b0;
      idx <= idx + 1'b1;
      if (last) begin
        result <= res_fin;
        flag_z <= (res_fin == '0);
        flag_s <= res_fin[WIDTH-1];
        flag_c <= arith ? alu_c_out : 1'b0;
        flag_v <= arith && (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                  (res_fin[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq with a behavioural 4-bit ALU and a word-level
// reference model.
module tb_alu_nibble_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op, lop;
  logic        cin;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_z, flag_c, flag_s, flag_v;
  logic [3:0]  alu_a, alu_b, alu_r;
  logic        alu_c_in, alu_l, alu_c_out;
  logic [1:0]  alu_op;
  logic [4:0]  alu_sum;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_res = 16'h0;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .lop(lop), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .flag_v(flag_v),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in), .alu_op(alu_op),
    .alu_l(alu_l), .alu_r(alu_r), .alu_c_out(alu_c_out)
  );

  // 4-bit ALU: logic ops AND/OR/XOR/NOT-A, otherwise A+B+c_in
  always_comb begin
    alu_r     = 4'h0;
    alu_c_out = 1'b0;
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_b} + {4'h0, alu_c_in};
    if (alu_l) begin
      case (alu_op)
        2'b00: alu_r = alu_a & alu_b;
        2'b01: alu_r = alu_a | alu_b;
        2'b10: alu_r = alu_a ^ alu_b;
        default: alu_r = ~alu_a;
      endcase
    end else begin
      alu_r     = alu_sum[3:0];
      alu_c_out = alu_sum[4];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word-level reference of the whole operation
  task automatic ref_model(input logic [1:0] o, input logic [1:0] l, input logic c,
                           input logic [15:0] av, input logic [15:0] bv,
                           output logic [15:0] r, output logic [3:0] zcsv,
                           output logic c0, output logic [15:0] beff);
    logic [16:0] full;
    beff = (o == 2'b10) ? ~bv : bv;
    c0   = (o == 2'b01) ? c : (o == 2'b10);
    if (o == 2'b11) begin
      case (l)
        2'b00: r = av & bv;
        2'b01: r = av | bv;
        2'b10: r = av ^ bv;
        default: r = ~av;
      endcase
      zcsv = {r == 16'h0, 1'b0, r[15], 1'b0};
    end else begin
      full = {1'b0, av} + {1'b0, beff} + {16'h0, c0};
      r    = full[15:0];
      zcsv = {r == 16'h0, full[16], r[15], (av[15] == beff[15]) && (r[15] != av[15])};
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [1:0] l, input logic c,
                       input logic [15:0] av, input logic [15:0] bv, input bit spam);
    logic [15:0] r_exp, beff;
    logic [3:0]  f_exp;
    logic        c0, prev_cout, got_done;
    int          n;
    ref_model(o, l, c, av, bv, r_exp, f_exp, c0, beff);
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    op = o; lop = l; cin = c; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1;
    start = spam; a = 16'($urandom); b = 16'($urandom); cin = ~c;
    n = 0; got_done = 1'b0; prev_cout = 1'b0;
    while (n < 12 && !got_done) begin
      @(negedge clk);
      n++;
      if (done) begin
        got_done = 1'b1;
        start = 1'b0;
        check("done_latency", n, 5);
        check("result", result, r_exp);
        check("flags_zcsv", {flag_z, flag_c, flag_s, flag_v}, f_exp);
        check("alu_zero_done", {alu_a, alu_b, alu_c_in, alu_op, alu_l}, 12'h0);
      end else begin
        check("run_busy", busy, 1'b1);
        check("result_held", result, last_res);
        check("alu_a", alu_a, av[4*(n-1) +: 4]);
        check("alu_b", alu_b, beff[4*(n-1) +: 4]);
        check("alu_l", alu_l, (o == 2'b11));
        check("alu_op", alu_op, (o == 2'b11) ? l : 2'b10);
        check("alu_c_in", alu_c_in, (o == 2'b11) ? 1'b0 : ((n == 1) ? c0 : prev_cout));
        prev_cout = alu_c_out;
      end
    end
    start = 1'b0;
    if (!got_done) check("done_timeout", 0, 1);
    last_res = r_exp;
    @(negedge clk);
    check("post_busy", {busy, done}, 2'b00);
    check("alu_zero_idle", {alu_a, alu_b, alu_c_in, alu_op, alu_l}, 12'h0);
  endtask

  task automatic reset_mid_run();
    int dones;
    @(negedge clk);
    op = 2'b00; lop = 2'b00; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_result", result, 16'h0);
    check("rst_flags", {flag_z, flag_c, flag_s, flag_v}, 4'h0);
    check("rst_alu", {alu_a, alu_b, alu_c_in, alu_op, alu_l}, 12'h0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("rst_no_done", dones, 0);
    last_res = 16'h0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; lop = 2'b00; cin = 1'b0; a = 16'h0; b = 16'h0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, result, flag_z, flag_c, flag_s, flag_v}, 22'h0);
    check("reset_alu", {alu_a, alu_b, alu_c_in, alu_op, alu_l}, 12'h0);
    reset = 1'b0;

    do_op(2'b00, 2'b00, 1'b0, 16'h1234, 16'h0FFF, 1'b0);
    do_op(2'b10, 2'b00, 1'b0, 16'h0005, 16'h0005, 1'b0);
    do_op(2'b10, 2'b00, 1'b0, 16'h0000, 16'h0001, 1'b0);
    do_op(2'b00, 2'b00, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    do_op(2'b01, 2'b00, 1'b1, 16'hFFFF, 16'h0000, 1'b0);
    do_op(2'b11, 2'b00, 1'b1, 16'hF0F0, 16'hFF00, 1'b0);
    do_op(2'b10, 2'b00, 1'b0, 16'h8000, 16'h0001, 1'b1);
    reset_mid_run();
    do_op(2'b00, 2'b00, 1'b0, 16'h00FF, 16'h0001, 1'b0);

    for (int k = 0; k < 60; k++) begin
      do_op(2'($urandom), 2'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
            bit'($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
